// File: rtl/mac_seq_ctrl.sv
// Iterative multiply-accumulate sequencer: Result = Acc + A*B mod 2^XLEN, BPC multiplier bits per cycle.
// Latency XLEN/BPC+1 cycles from accept to Done (down to 2 with MAC_SEQ_EARLYOUT_EN defined).
// Backpressure: Ready low and StallE high while an operation is in flight; Kill aborts without side effects.
module mac_seq_ctrl #(
  parameter int XLEN = 64,
  parameter int BPC  = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            Start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            AccClr,
  input  logic            Kill,
  output logic            Ready,
  output logic            StallE,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic [XLEN-1:0] Acc
);

  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplr;
  logic [XLEN-1:0] part;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] acc_q;
  logic [CW-1:0]   cnt;
  logic            ready_q;
  logic            stall_q;
  logic            done_q;

  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] mplr_digit;
  logic [XLEN-1:0] start_base;
  logic            last_step;

  // Partial product for the current BPC-bit multiplier digit, plus the base the next op starts from.
  always_comb begin
    mplr_digit = '0;
    mplr_digit[BPC-1:0] = mplr[BPC-1:0];
    addend     = mcand * mplr_digit;
    start_base = AccClr ? '0 : acc_q;
`ifdef MAC_SEQ_EARLYOUT_EN
    // Remaining multiplier digits all zero: further steps would only add zero.
    last_step  = (cnt == '0) || ((mplr >> BPC) == '0);
`else
    last_step  = (cnt == '0);
`endif
  end

  // Sequencer state, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      part    <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Kill) begin
            mcand   <= A;
            mplr    <= B;
            part    <= start_base;
            acc_q   <= start_base;
            cnt     <= CW'(STEPS - 1);
            state   <= RUN;
            ready_q <= 1'b0;
            stall_q <= 1'b1;
          end else if (AccClr) begin
            acc_q <= '0;
          end
        end
        RUN: begin
          if (Kill) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            stall_q <= 1'b0;
          end else begin
            part  <= part + addend;
            mcand <= mcand << BPC;
            mplr  <= mplr >> BPC;
            if (last_step) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        DONE: begin
          // A flush in the completion cycle drops the writeback.
          if (!Kill) begin
            res_q <= part;
            acc_q <= part;
          end
          state   <= IDLE;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Result follows the live partial sum during the Done cycle, otherwise the last committed value.
  always_comb begin
    Ready  = ready_q;
    StallE = stall_q;
    Done   = done_q;
    Result = done_q ? part : res_q;
    Acc    = acc_q;
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized scoreboard bench for mac_seq_ctrl (XLEN=64, BPC=2).
// Stimulus pushes expected result/latency on accept; a negedge monitor pops on Done.
// Reference model is plain 64-bit arithmetic plus a digit-count latency rule.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Start;
  logic [63:0] A;
  logic [63:0] B;
  logic        AccClr;
  logic        Kill;
  logic        Ready;
  logic        StallE;
  logic        Done;
  logic [63:0] Result;
  logic [63:0] Acc;

  mac_seq_ctrl #(.XLEN(64), .BPC(2)) dut (
    .clk(clk), .resetn(resetn), .Start(Start), .A(A), .B(B),
    .AccClr(AccClr), .Kill(Kill), .Ready(Ready), .StallE(StallE),
    .Done(Done), .Result(Result), .Acc(Acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [63:0] acc_pre;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  logic [63:0] acc_m  = '0;
  logic [63:0] last_res = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Number of RUN cycles: one per 2-bit digit, optionally stopping once the remaining digits are zero.
  function automatic int run_edges(input logic [63:0] b);
`ifdef MAC_SEQ_EARLYOUT_EN
    for (int i = 1; i < 32; i++)
      if ((b >> (2 * i)) == 64'd0) return i;
`endif
    return 32;
  endfunction

  // Returns at #1 after a rising edge with Ready high (bounded).
  task automatic wait_ready();
    int guard = 0;
    while (!Ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
      if (!Ready) AccClr = 1'($urandom % 2);
    end
    check("ready_timeout", {63'd0, Ready}, 64'd1);
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic clr,
                    input int kill_j, input logic keep);
    logic [63:0] base;
    exp_t        e;
    int          n;
    int          kj;
    wait_ready();
    Start = 1'b1; A = a; B = b; AccClr = clr; Kill = 1'b0;
    @(posedge clk); #1;
    base = clr ? 64'd0 : acc_m;
    n    = run_edges(b);
    if (!keep) Start = 1'b0;
    AccClr = 1'($urandom % 2);
    if (kill_j == 0) begin
      e.res      = base + a * b;
      e.acc_pre  = base;
      e.done_cyc = cyc + n;
      sb.push_back(e);
      acc_m = e.res;
    end else begin
      kj = (kill_j > n) ? n : kill_j;
      repeat (kj - 1) begin
        @(posedge clk); #1;
        AccClr = 1'($urandom % 2);
      end
      Kill = 1'b1;
      @(posedge clk); #1;
      Kill   = 1'b0;
      AccClr = 1'b0;
      acc_m  = base;
      check("ready_after_kill", {63'd0, Ready}, 64'd1);
      check("acc_after_kill", Acc, base);
    end
  endtask

  // Monitor: pops the scoreboard on every Done and checks holding behaviour otherwise.
  initial begin
    exp_t        e;
    logic        acc_pending = 1'b0;
    logic [63:0] acc_exp = '0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        acc_pending = 1'b0;
        continue;
      end
      if (acc_pending) begin
        check("acc_after_done", Acc, acc_exp);
        acc_pending = 1'b0;
      end
      check("stalle_vs_ready", {63'd0, StallE}, {63'd0, ~Ready});
      if (Done) begin
        check("done_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("result", Result, e.res);
          check("acc_during_done", Acc, e.acc_pre);
          check("done_latency", 64'(cyc), 64'(e.done_cyc));
          last_res    = e.res;
          acc_exp     = e.res;
          acc_pending = 1'b1;
        end
      end else begin
        check("result_hold", Result, last_res);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    resetn = 1'b0; Start = 1'b1; A = 64'd5; B = 64'd3; AccClr = 1'b0; Kill = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready",  {63'd0, Ready},  64'd1);
    check("rst_stalle", {63'd0, StallE}, 64'd0);
    check("rst_done",   {63'd0, Done},   64'd0);
    check("rst_acc",    Acc,    64'd0);
    check("rst_result", Result, 64'd0);
    Start  = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed sequence from the test plan.
    op(64'd5, 64'd3, 1'b0, 0, 1'b0);                    // 15
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 0, 1'b0);  // wraps to 0xD
    op(64'd2, 64'd2, 1'b1, 0, 1'b0);                    // Acc = 4
    op(64'd7, 64'd9, 1'b0, 10, 1'b0);                   // killed, Acc stays 4
    op(64'd10, 64'd10, 1'b1, 0, 1'b0);                  // Acc = 100
    op(64'd6, 64'd7, 1'b1, 0, 1'b0);                    // AccClr on accept -> 42
    op(64'd2, 64'd3, 1'b1, 0, 1'b1);                    // held Start: 6
    op(64'd2, 64'd3, 1'b0, 0, 1'b1);                    // 12
    op(64'd2, 64'd3, 1'b0, 0, 1'b0);                    // 18

    // Random operations with occasional kills and AccClr.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      case ($urandom % 3)
        0:       b = 64'($urandom % 16);
        1:       b = {$urandom, $urandom};
        default: b = 64'($urandom);
      endcase
      op(a, b, 1'($urandom % 4 == 0), ($urandom % 5 == 0) ? int'(1 + $urandom % 32) : 0, 1'b0);
    end

    AccClr = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
